// File: rtl/dig_to_count16bit.sv
// rtl/dig_to_count16bit.sv - calculator-style digit entry assembler producing a 16-bit count
//
// Purpose: shifts 4-bit digits in newest-in-LSB, delivers the assembled value
//          on commit with a one-cycle strobe, and exposes the live entry.
// Ports:
//   clk, reset_n              clock (rising edge), asynchronous active-low reset
//   dig_in/dig_valid/dig_ready digit stream handshake (ready is combinational)
//   backspace, clear, commit  single-cycle commands, priority clear > commit > backspace > digit
//   entry, ndig               live right-justified entry and digit count (0..NDIG)
//   count_out, count_valid    last committed value and its one-cycle update strobe
//   err                       one-cycle strobe: rejected non-BCD digit or empty commit
module dig_to_count16bit #(
    parameter bit BCD_ONLY = 1'b0,
    parameter int NDIG     = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [3:0]          dig_in,
    input  logic                dig_valid,
    output logic                dig_ready,
    input  logic                backspace,
    input  logic                clear,
    input  logic                commit,
    output logic [4*NDIG-1:0]   entry,
    output logic [2:0]          ndig,
    output logic [4*NDIG-1:0]   count_out,
    output logic                count_valid,
    output logic                err
);

    localparam int W = 4 * NDIG;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_ENTRY,
        S_FULL
    } state_t;

    logic [W-1:0] r_entry;
    logic [2:0]   r_ndig;
    logic [W-1:0] r_count;
    logic         r_count_valid;
    logic         r_err;

    state_t       w_state;
    logic         w_take;
    logic         w_bad_digit;
    logic [W-1:0] w_entry_nxt;
    logic [2:0]   w_ndig_nxt;
    logic [W-1:0] w_count_nxt;
    logic         w_count_valid_nxt;
    logic         w_err_nxt;

    // The state is a pure function of the digit count; no separate register.
    always_comb begin
        w_state = S_ENTRY;
        if (r_ndig == 3'd0) begin
            w_state = S_EMPTY;
        end else if (r_ndig == 3'(NDIG)) begin
            w_state = S_FULL;
        end
    end

    // Any command pending this cycle blocks the digit path so a held digit is not lost.
    assign dig_ready   = (w_state != S_FULL) && !clear && !commit && !backspace;
    assign w_take      = dig_valid && dig_ready;
    assign w_bad_digit = BCD_ONLY && (dig_in > 4'd9);

    always_comb begin
        w_entry_nxt       = r_entry;
        w_ndig_nxt        = r_ndig;
        w_count_nxt       = r_count;
        w_count_valid_nxt = 1'b0;
        w_err_nxt         = 1'b0;
        if (clear) begin
            w_entry_nxt = '0;
            w_ndig_nxt  = 3'd0;
        end else if (commit) begin
            if (w_state != S_EMPTY) begin
                w_count_nxt       = r_entry;
                w_count_valid_nxt = 1'b1;
                w_entry_nxt       = '0;
                w_ndig_nxt        = 3'd0;
            end else begin
                w_err_nxt = 1'b1;
            end
        end else if (backspace) begin
            if (w_state != S_EMPTY) begin
                w_entry_nxt = {4'h0, r_entry[W-1:4]};
                w_ndig_nxt  = r_ndig - 3'd1;
            end
        end else if (w_take) begin
            // A rejected digit is still consumed by the handshake; only err reports it.
            if (w_bad_digit) begin
                w_err_nxt = 1'b1;
            end else begin
                w_entry_nxt = {r_entry[W-5:0], dig_in};
                w_ndig_nxt  = r_ndig + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_entry       <= '0;
            r_ndig        <= 3'd0;
            r_count       <= '0;
            r_count_valid <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_entry       <= w_entry_nxt;
            r_ndig        <= w_ndig_nxt;
            r_count       <= w_count_nxt;
            r_count_valid <= w_count_valid_nxt;
            r_err         <= w_err_nxt;
        end
    end

    assign entry       = r_entry;
    assign ndig        = r_ndig;
    assign count_out   = r_count;
    assign count_valid = r_count_valid;
    assign err         = r_err;

endmodule

// File: tb/tb_dig_to_count16bit.sv
// tb/tb_dig_to_count16bit.sv - self-checking bench for dig_to_count16bit (hex and BCD instances)
module tb_dig_to_count16bit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  dig_in;
    logic        dig_valid;
    logic        backspace;
    logic        clear;
    logic        commit;

    logic        ready_o [2];
    logic [15:0] entry_o [2];
    logic [2:0]  ndig_o  [2];
    logic [15:0] count_o [2];
    logic        cval_o  [2];
    logic        err_o   [2];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: held digits as a queue, committed value, strobes.
    int unsigned mq [2][$];
    int unsigned m_count [2];
    int unsigned m_cval  [2];
    int unsigned m_err   [2];

    always #5 clk = ~clk;

    dig_to_count16bit #(.BCD_ONLY(1'b0), .NDIG(4)) u_hex (
        .clk(clk), .reset_n(reset_n), .dig_in(dig_in), .dig_valid(dig_valid),
        .dig_ready(ready_o[0]), .backspace(backspace), .clear(clear), .commit(commit),
        .entry(entry_o[0]), .ndig(ndig_o[0]), .count_out(count_o[0]),
        .count_valid(cval_o[0]), .err(err_o[0])
    );

    dig_to_count16bit #(.BCD_ONLY(1'b1), .NDIG(4)) u_bcd (
        .clk(clk), .reset_n(reset_n), .dig_in(dig_in), .dig_valid(dig_valid),
        .dig_ready(ready_o[1]), .backspace(backspace), .clear(clear), .commit(commit),
        .entry(entry_o[1]), .ndig(ndig_o[1]), .count_out(count_o[1]),
        .count_valid(cval_o[1]), .err(err_o[1])
    );

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int unsigned mval(input int k);
        int unsigned v = 0;
        for (int i = 0; i < mq[k].size(); i++) v = v * 16 + mq[k][i];
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            m_count[k] = 0;
            m_cval[k]  = 0;
            m_err[k]   = 0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            m_cval[k] = 0;
            m_err[k]  = 0;
            if (clear) begin
                mq[k].delete();
            end else if (commit) begin
                if (mq[k].size() > 0) begin
                    m_count[k] = mval(k);
                    m_cval[k]  = 1;
                    mq[k].delete();
                end else begin
                    m_err[k] = 1;
                end
            end else if (backspace) begin
                if (mq[k].size() > 0) void'(mq[k].pop_back());
            end else if (dig_valid && mq[k].size() < 4) begin
                if (k == 1 && dig_in > 9) m_err[k] = 1;
                else mq[k].push_back(int'(dig_in));
            end
        end
    endtask

    task automatic check_outs(input string tag);
        for (int k = 0; k < 2; k++) begin
            check({tag, (k == 0) ? ".hex.entry" : ".bcd.entry"}, entry_o[k], mval(k));
            check({tag, (k == 0) ? ".hex.ndig"  : ".bcd.ndig"},  ndig_o[k],  mq[k].size());
            check({tag, (k == 0) ? ".hex.count" : ".bcd.count"}, count_o[k], m_count[k]);
            check({tag, (k == 0) ? ".hex.cval"  : ".bcd.cval"},  cval_o[k],  m_cval[k]);
            check({tag, (k == 0) ? ".hex.err"   : ".bcd.err"},   err_o[k],   m_err[k]);
        end
    endtask

    // Called just after a falling edge: drive, check ready, clock, then check outputs.
    task automatic step(input string tag, input logic [3:0] d, input logic v,
                        input logic b, input logic c, input logic m);
        dig_in = d; dig_valid = v; backspace = b; clear = c; commit = m;
        #1;
        for (int k = 0; k < 2; k++)
            check({tag, ".ready"}, ready_o[k],
                  (mq[k].size() < 4 && !c && !m && !b) ? 1 : 0);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outs(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic async_reset(input string tag);
        #2;
        reset_n = 1'b0;
        dig_valid = 1'b0; backspace = 1'b0; clear = 1'b0; commit = 1'b0;
        #1;
        model_reset();
        check_outs(tag);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) check({tag, ".ready_after"}, ready_o[k], 1);
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        dig_in = 4'h0; dig_valid = 1'b0; backspace = 1'b0; clear = 1'b0; commit = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outs("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Fill 1,2,3,4 then a held-off A
        step("d1", 4'h1, 1'b1, 1'b0, 1'b0, 1'b0);
        step("d2", 4'h2, 1'b1, 1'b0, 1'b0, 1'b0);
        step("d3", 4'h3, 1'b1, 1'b0, 1'b0, 1'b0);
        step("d4", 4'h4, 1'b1, 1'b0, 1'b0, 1'b0);
        check("full.entry", entry_o[0], 32'h1234);
        step("full_A", 4'hA, 1'b1, 1'b0, 1'b0, 1'b0);
        step("commit1234", 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("commit.count", count_o[0], 32'h1234);
        for (int i = 0; i < 10; i++) idle("hold");

        // Backspace sequence
        step("d7", 4'h7, 1'b1, 1'b0, 1'b0, 1'b0);
        step("d8", 4'h8, 1'b1, 1'b0, 1'b0, 1'b0);
        step("bs", 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("bs.entry", entry_o[0], 32'h0007);
        step("d9", 4'h9, 1'b1, 1'b0, 1'b0, 1'b0);
        check("d9.entry", entry_o[0], 32'h0079);
        step("clr", 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("bs_empty", 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Simultaneous digit, backspace and commit
        step("d4b", 4'h4, 1'b1, 1'b0, 1'b0, 1'b0);
        step("d2b", 4'h2, 1'b1, 1'b0, 1'b0, 1'b0);
        step("prio", 4'h5, 1'b1, 1'b1, 1'b0, 1'b1);
        check("prio.count", count_o[0], 32'h0042);

        // Non-BCD digit and empty commit
        step("d3c", 4'h3, 1'b1, 1'b0, 1'b0, 1'b0);
        step("dC", 4'hC, 1'b1, 1'b0, 1'b0, 1'b0);
        check("bcd.entry", entry_o[1], 32'h0003);
        check("bcd.err", err_o[1], 1);
        step("clr2", 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("commit_empty", 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Leading zeros
        step("z0", 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("z1", 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("z2", 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("z5", 4'h5, 1'b1, 1'b0, 1'b0, 1'b0);
        check("zeros.ndig", ndig_o[0], 4);

        // Reset mid-entry, and during a count_valid cycle
        step("r5", 4'h5, 1'b1, 1'b0, 1'b0, 1'b0);
        step("r6", 4'h6, 1'b1, 1'b0, 1'b0, 1'b0);
        async_reset("rst_mid");
        step("s1", 4'h1, 1'b1, 1'b0, 1'b0, 1'b0);
        step("s_commit", 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        async_reset("rst_cval");

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int unsigned r = $urandom_range(0, 99);
            logic [3:0] d = 4'($urandom_range(0, 15));
            logic v = ($urandom_range(0, 99) < 70);
            logic b = (r < 12);
            logic c = (r >= 12 && r < 16) || ($urandom_range(0, 99) < 2);
            logic m = (r >= 16 && r < 26) || ($urandom_range(0, 99) < 2);
            step("rnd", d, v, b, c, m);
            if (i == 1500) async_reset("rst_rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
